// File: rtl/tmc_pio_write_arbiter.sv
// tmc_pio_write_arbiter
// Avalon-MM master that shares one output PIO slave among NUM_REQ requesters.
// Grants are round-robin. Each grant produces one zero-wait-state write of the
// granted requester's data to PIO address 0.
// An optional idle dwell of HOLD_CYCLES follows every write.
// Optional readback check: define TMC_PIO_ARB_VERIFY_EN to add a one-cycle
// VERIFY read after each write and a sticky verify_err flag.
module tmc_pio_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [2:0]                last_grant,
  output logic [1:0]                avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [31:0]               avm_writedata,
  input  logic [31:0]               avm_readdata,
  output logic                      verify_err,
  input  logic                      verify_err_clr
);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StVerify,
    StHold
  } state_e;

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES);

  state_e              state_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                busy_q;
  logic [2:0]          lastGrant_q;
  logic                chipselect_q;
  logic                writeN_q;
  logic [31:0]         writedata_q;
  logic [7:0]          holdCnt_q;

  logic                pickValid_d;
  logic [2:0]          pickIdx_d;
  logic [NUM_REQ-1:0]  pickOneHot_d;
  logic [DATA_W-1:0]   pickData_d;

  logic                unusedSink;

  // Round-robin pick: scan from the requester after the last grant and wrap,
  // so the most recently served index always ends up with lowest priority.
  always_comb begin
    pickValid_d  = 1'b0;
    pickIdx_d    = '0;
    pickOneHot_d = '0;
    pickData_d   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pickValid_d && req[i] && (i == ((int'(lastGrant_q) + k) % NUM_REQ))) begin
          pickValid_d     = 1'b1;
          pickIdx_d       = 3'(i);
          pickOneHot_d[i] = 1'b1;
          pickData_d      = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Main FSM; every bus-facing output is registered so the PIO sees clean strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      lastGrant_q  <= 3'(NUM_REQ - 1);
      chipselect_q <= 1'b0;
      writeN_q     <= 1'b1;
      writedata_q  <= '0;
      holdCnt_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        StIdle: begin
          if (pickValid_d) begin
            state_q      <= StWrite;
            busy_q       <= 1'b1;
            lastGrant_q  <= pickIdx_d;
            ack_q        <= pickOneHot_d;
            chipselect_q <= 1'b1;
            writeN_q     <= 1'b0;
            writedata_q  <= 32'(pickData_d);
          end
        end
        StWrite: begin
          writeN_q <= 1'b1;
`ifdef TMC_PIO_ARB_VERIFY_EN
          state_q      <= StVerify;
          chipselect_q <= 1'b1;
`else
          chipselect_q <= 1'b0;
          if (HOLD_CYCLES > 0) begin
            state_q   <= StHold;
            holdCnt_q <= HoldLoad;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`endif
        end
        StVerify: begin
          chipselect_q <= 1'b0;
          writeN_q     <= 1'b1;
          if (HOLD_CYCLES > 0) begin
            state_q   <= StHold;
            holdCnt_q <= HoldLoad;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StHold: begin
          if (holdCnt_q <= 8'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            holdCnt_q <= holdCnt_q - 8'd1;
          end
        end
        default: begin
          state_q      <= StIdle;
          busy_q       <= 1'b0;
          chipselect_q <= 1'b0;
          writeN_q     <= 1'b1;
        end
      endcase
    end
  end

`ifdef TMC_PIO_ARB_VERIFY_EN
  logic verifyErr_q;

  // Sticky readback flag; a fresh mismatch takes precedence over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      verifyErr_q <= 1'b0;
    end else if ((state_q == StVerify) &&
                 (avm_readdata[DATA_W-1:0] != writedata_q[DATA_W-1:0])) begin
      verifyErr_q <= 1'b1;
    end else if (verify_err_clr) begin
      verifyErr_q <= 1'b0;
    end
  end

  assign verify_err = verifyErr_q;
`else
  assign verify_err = 1'b0;
`endif

  assign unusedSink     = ^{avm_readdata, verify_err_clr};

  assign ack            = ack_q;
  assign busy           = busy_q;
  assign last_grant     = lastGrant_q;
  assign avm_address    = 2'b00;
  assign avm_chipselect = chipselect_q;
  assign avm_write_n    = writeN_q;
  assign avm_writedata  = writedata_q;

endmodule

// File: tb/tb_tmc_pio_write_arbiter.sv
// tb_tmc_pio_write_arbiter
// Scoreboard bench for tmc_pio_write_arbiter. One instance runs with no dwell
// and carries the scoreboard. A second instance runs with HOLD_CYCLES=5 for dwell timing.
// Works with or without TMC_PIO_ARB_VERIFY_EN defined.
`timescale 1ns/1ps
module tb_tmc_pio_write_arbiter;

`ifdef TMC_PIO_ARB_VERIFY_EN
  localparam int VerifyExtra = 1;
`else
  localparam int VerifyExtra = 0;
`endif
  localparam int WritePeriod = 2 + VerifyExtra;
  localparam int HoldPeriod  = 7 + VerifyExtra;

  typedef struct {
    logic [3:0]  ack;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  ack;
  logic        busy;
  logic [2:0]  lastGrant;
  logic [1:0]  avmAddress;
  logic        avmChipselect;
  logic        avmWriteN;
  logic [31:0] avmWritedata;
  logic [31:0] avmReaddata;
  logic        verifyErr;
  logic        verifyErrClr;
  logic        corruptRead;
  logic [7:0]  pioOut;

  logic        hReset;
  logic [3:0]  hReq;
  logic [31:0] hReqData;
  logic [3:0]  hAck;
  logic        hBusy;
  logic [2:0]  hLastGrant;
  logic [1:0]  hAddress;
  logic        hChipselect;
  logic        hWriteN;
  logic [31:0] hWritedata;
  logic [31:0] hReaddata;
  logic        hVerifyErr;
  logic [7:0]  hPioOut;

  // Free-running system clock
  always #5 clk = ~clk;

  tmc_pio_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(reqData), .ack(ack),
    .busy(busy), .last_grant(lastGrant), .avm_address(avmAddress),
    .avm_chipselect(avmChipselect), .avm_write_n(avmWriteN),
    .avm_writedata(avmWritedata), .avm_readdata(avmReaddata),
    .verify_err(verifyErr), .verify_err_clr(verifyErrClr)
  );

  tmc_pio_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(5)) dutH (
    .clk(clk), .reset(hReset), .req(hReq), .req_data(hReqData), .ack(hAck),
    .busy(hBusy), .last_grant(hLastGrant), .avm_address(hAddress),
    .avm_chipselect(hChipselect), .avm_write_n(hWriteN),
    .avm_writedata(hWritedata), .avm_readdata(hReaddata),
    .verify_err(hVerifyErr), .verify_err_clr(1'b0)
  );

  // PIO slave models: latch the byte on a write strobe to address 0
  always @(posedge clk) begin
    if (reset) pioOut <= 8'h00;
    else if (avmChipselect && !avmWriteN && avmAddress == 2'b00) pioOut <= avmWritedata[7:0];
    if (hReset) hPioOut <= 8'h00;
    else if (hChipselect && !hWriteN && hAddress == 2'b00) hPioOut <= hWritedata[7:0];
  end

  assign avmReaddata = corruptRead ? 32'h0000000F : {24'h0, pioOut};
  assign hReaddata   = {24'h0, hPioOut};

  // Scoreboard monitor: every write strobe on the main instance must match the next expected write
  always @(negedge clk) begin
    exp_t e;
    if (avmChipselect && !avmWriteN) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_write: got ack=%b data=%h, expected no write", ack, avmWritedata);
      end else begin
        e = expQ.pop_front();
        if (ack !== e.ack || avmWritedata !== e.data || avmAddress !== 2'b00) begin
          failures++;
          $display("[TB] FAIL sb_write: got ack=%b data=%h addr=%0d, expected ack=%b data=%h addr=0",
                   ack, avmWritedata, avmAddress, e.ack, e.data);
        end
      end
    end
  end

  function automatic exp_t mkExp(input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.ack  = a;
    e.data = d;
    return e;
  endfunction

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; reqData = '0; verifyErrClr = 1'b0; corruptRead = 1'b0;
    hReset = 1'b1; hReq = '0; hReqData = '0;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack: got %b, expected 0000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (avmChipselect !== 1'b0) begin failures++; $display("[TB] FAIL reset_cs: got %b, expected 0", avmChipselect); end
    checks++; if (avmWriteN !== 1'b1) begin failures++; $display("[TB] FAIL reset_write_n: got %b, expected 1", avmWriteN); end
    checks++; if (avmWritedata !== 32'h0) begin failures++; $display("[TB] FAIL reset_writedata: got %h, expected 0", avmWritedata); end
    checks++; if (lastGrant !== 3'd3) begin failures++; $display("[TB] FAIL reset_last_grant: got %0d, expected 3", lastGrant); end
    checks++; if (verifyErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_verify_err: got %b, expected 0", verifyErr); end
    reset = 1'b0;
    hReset = 1'b0;
  endtask

  task automatic test_single_write();
    bit ok;
    req = 4'b0001; reqData[7:0] = 8'hA5;
    expQ.push_back(mkExp(4'b0001, 32'h000000A5));
    @(negedge clk);
    checks++; if (avmChipselect !== 1'b1 || avmWriteN !== 1'b0) begin failures++; $display("[TB] FAIL single_strobe: got cs=%b wn=%b, expected cs=1 wn=0", avmChipselect, avmWriteN); end
    checks++; if (avmWritedata !== 32'h000000A5) begin failures++; $display("[TB] FAIL single_data: got %h, expected 000000a5", avmWritedata); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL single_ack: got %b, expected 0001", ack); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (pioOut !== 8'hA5) begin failures++; $display("[TB] FAIL single_pio: got %h, expected a5", pioOut); end
    waitIdle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL single_idle_timeout: got busy=%b, expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int nWrites = 0;
    int lastCyc = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reqData = 32'h13121110;
    expQ.push_back(mkExp(4'b0001, 32'h10));
    expQ.push_back(mkExp(4'b0010, 32'h11));
    expQ.push_back(mkExp(4'b0100, 32'h12));
    expQ.push_back(mkExp(4'b1000, 32'h13));
    expQ.push_back(mkExp(4'b0001, 32'h10));
    req = 4'b1111;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (avmChipselect && !avmWriteN) begin
        nWrites++;
        if (nWrites == 1) begin
          checks++; if (cyc !== 1) begin failures++; $display("[TB] FAIL rr_latency: got %0d cycles, expected 1", cyc); end
        end else begin
          checks++; if (cyc - lastCyc !== WritePeriod) begin failures++; $display("[TB] FAIL rr_spacing: got %0d cycles, expected %0d", cyc - lastCyc, WritePeriod); end
        end
        lastCyc = cyc;
        if (nWrites == 5) begin
          req = 4'b0000;
          break;
        end
      end
    end
    checks++; if (nWrites !== 5) begin failures++; $display("[TB] FAIL rr_count: got %0d writes, expected 5", nWrites); end
    checks++; if (lastGrant !== 3'd0) begin failures++; $display("[TB] FAIL rr_last_grant: got %0d, expected 0", lastGrant); end
  endtask

  task automatic test_data_sampling();
    bit ok;
    waitIdle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL sample_idle_timeout: got busy=%b, expected 0", busy); end
    req = 4'b0010; reqData[15:8] = 8'h11;
    expQ.push_back(mkExp(4'b0010, 32'h00000011));
    @(posedge clk);
    #1 reqData[15:8] = 8'h22;
    @(negedge clk);
    checks++; if (avmWritedata !== 32'h00000011) begin failures++; $display("[TB] FAIL sample_data: got %h, expected 00000011", avmWritedata); end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (pioOut !== 8'h11) begin failures++; $display("[TB] FAIL sample_pio: got %h, expected 11", pioOut); end
    checks++; if (lastGrant !== 3'd1) begin failures++; $display("[TB] FAIL sample_last_grant: got %0d, expected 1", lastGrant); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    waitIdle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_idle_timeout: got busy=%b, expected 0", busy); end
    req = 4'b0100; reqData = 32'h44333231;
    expQ.push_back(mkExp(4'b0100, 32'h00000033));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (avmChipselect !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_outputs: got cs=%b busy=%b, expected cs=0 busy=0", avmChipselect, busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL rst_mid_ack: got %b, expected 0000", ack); end
    checks++; if (lastGrant !== 3'd3) begin failures++; $display("[TB] FAIL rst_mid_last_grant: got %0d, expected 3", lastGrant); end
    reset = 1'b0;
    req = 4'b1111;
    expQ.push_back(mkExp(4'b0001, 32'h00000031));
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL rst_next_grant: got %b, expected 0001", ack); end
    req = 4'b0000;
  endtask

  task automatic test_hold();
    logic [3:0]  expAck[3]  = '{4'b0001, 4'b0100, 4'b0001};
    logic [31:0] expData[3] = '{32'h40, 32'h42, 32'h40};
    int nWrites = 0;
    int lastCyc = 0;
    int busyCnt = 0;
    hReqData = 32'h00420040;
    hReq = 4'b0101;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (hChipselect && !hWriteN) begin
        checks++;
        if (hAck !== expAck[nWrites] || hWritedata !== expData[nWrites]) begin
          failures++;
          $display("[TB] FAIL hold_write: got ack=%b data=%h, expected ack=%b data=%h", hAck, hWritedata, expAck[nWrites], expData[nWrites]);
        end
        if (nWrites > 0) begin
          checks++; if (cyc - lastCyc !== HoldPeriod) begin failures++; $display("[TB] FAIL hold_spacing: got %0d cycles, expected %0d", cyc - lastCyc, HoldPeriod); end
          checks++; if (busyCnt !== HoldPeriod - 2) begin failures++; $display("[TB] FAIL hold_busy: got %0d busy cycles, expected %0d", busyCnt, HoldPeriod - 2); end
        end
        nWrites++;
        lastCyc = cyc;
        busyCnt = 0;
        if (nWrites == 3) begin
          hReq = 4'b0000;
          break;
        end
      end else if (nWrites > 0 && hBusy) begin
        busyCnt++;
      end
    end
    checks++; if (nWrites !== 3) begin failures++; $display("[TB] FAIL hold_count: got %0d writes, expected 3", nWrites); end
    @(negedge clk);
    hReset = 1'b1;
    @(negedge clk);
    checks++; if (hBusy !== 1'b0 || hChipselect !== 1'b0 || hAck !== 4'b0000) begin failures++; $display("[TB] FAIL hold_reset: got busy=%b cs=%b ack=%b, expected 0 0 0000", hBusy, hChipselect, hAck); end
    hReset = 1'b0;
  endtask

  task automatic test_verify();
    bit ok;
    waitIdle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL verify_idle_timeout: got busy=%b, expected 0", busy); end
    corruptRead = 1'b1;
    req = 4'b0001; reqData[7:0] = 8'hF0;
    expQ.push_back(mkExp(4'b0001, 32'h000000F0));
    @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);
`ifdef TMC_PIO_ARB_VERIFY_EN
    checks++; if (verifyErr !== 1'b1) begin failures++; $display("[TB] FAIL verify_set: got %b, expected 1", verifyErr); end
    corruptRead = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (verifyErr !== 1'b1) begin failures++; $display("[TB] FAIL verify_sticky: got %b, expected 1", verifyErr); end
    verifyErrClr = 1'b1;
    @(negedge clk);
    verifyErrClr = 1'b0;
    checks++; if (verifyErr !== 1'b0) begin failures++; $display("[TB] FAIL verify_clear: got %b, expected 0", verifyErr); end
`else
    verifyErrClr = 1'b1;
    @(negedge clk);
    verifyErrClr = 1'b0;
    checks++; if (verifyErr !== 1'b0) begin failures++; $display("[TB] FAIL verify_tied_low: got %b, expected 0", verifyErr); end
    corruptRead = 1'b0;
`endif
  endtask

  // Sequence the scenarios, drain the scoreboard, report
  initial begin
    bit drained;
    test_reset();
    test_single_write();
    test_round_robin();
    test_data_sampling();
    test_reset_mid_write();
    test_hold();
    test_verify();
    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++; if (!drained) begin failures++; $display("[TB] FAIL sb_drain: got %0d pending writes, expected 0", expQ.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish before 200000ns");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
